// File: rtl/ledowner.sv
// ledowner: picks the LED source (bouncer pattern, software value or alert blink) behind a Wishbone slave.
// Define LEDOWNER_TIMEOUT_EN to return SOFT ownership to the bouncer after TIMEOUT idle cycles.
module ledowner #(
   parameter int NLEDS        = 8,
   parameter int TIMEOUT      = 100_000_000,
   parameter int ALERT_CYCLES = 50_000_000,
   parameter int BLINKBIT     = 22
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic [NLEDS-1:0] i_bounce,
   input  logic             i_alert,
   input  logic             i_wb_cyc,
   input  logic             i_wb_stb,
   input  logic             i_wb_we,
   input  logic [1:0]       i_wb_addr,
   input  logic [31:0]      i_wb_data,
   input  logic [3:0]       i_wb_sel,
   output logic             o_wb_stall,
   output logic             o_wb_ack,
   output logic [31:0]      o_wb_data,
   output logic [NLEDS-1:0] o_leds
);

   localparam logic [1:0] ST_BOUNCE = 2'd0;
   localparam logic [1:0] ST_SOFT   = 2'd1;
   localparam logic [1:0] ST_ALERT  = 2'd2;

   localparam int            AW           = $clog2(ALERT_CYCLES);
   localparam logic [AW-1:0] ALERT_RELOAD = AW'(ALERT_CYCLES - 1);

   logic [1:0]       state_q, state_d;
   logic             saved_q, saved_d;
   logic [NLEDS-1:0] soft_q, soft_d;
   logic [NLEDS-1:0] leds_q, leds_d;
   logic [AW-1:0]    alert_ctr_q, alert_ctr_d;
   logic             ack_q, ack_d;
   logic [31:0]      rdata_q, rdata_d;

   logic             wr, wr_leds, wr_release, trigger;
   logic             in_alert, cur_owner, next_owner, tmo_expired;
   logic [NLEDS-1:0] wr_mask, wr_val;
   logic             unused_bits;

   assign wr         = i_wb_stb && i_wb_we;
   assign wr_leds    = wr && (i_wb_addr == 2'd0);
   assign wr_release = wr && (i_wb_addr == 2'd2);
   assign trigger    = i_alert || (wr && (i_wb_addr == 2'd3));

   // The owner to return to is a single bit (1 = SOFT); during an alert it lives in saved_q.
   assign in_alert  = (state_q == ST_ALERT);
   assign cur_owner = in_alert ? saved_q : state_q[0];

`ifdef LEDOWNER_TIMEOUT_EN
   localparam int            TW         = $clog2(TIMEOUT);
   localparam logic [TW-1:0] TMO_RELOAD = TW'(TIMEOUT - 1);

   logic [TW-1:0] tmo_ctr_q, tmo_ctr_d;

   // Counts down whenever software owns the LEDs, even while that ownership is parked by an alert.
   assign tmo_expired = cur_owner && (tmo_ctr_q == '0);

   always_comb begin
      tmo_ctr_d = tmo_ctr_q;
      if (wr_leds) begin
         tmo_ctr_d = TMO_RELOAD;
      end else if (cur_owner && (tmo_ctr_q != '0)) begin
         tmo_ctr_d = tmo_ctr_q - TW'(1);
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) tmo_ctr_q <= '0;
      else         tmo_ctr_q <= tmo_ctr_d;
   end
`else
   localparam int unused_timeout = TIMEOUT;
   assign tmo_expired = 1'b0;
`endif

   // A write in the same cycle as an expiring timeout wins.
   always_comb begin
      next_owner = cur_owner;
      if (wr_leds) begin
         next_owner = 1'b1;
      end else if (wr_release || tmo_expired) begin
         next_owner = 1'b0;
      end
   end

   // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      state_d     = state_q;
      saved_d     = saved_q;
      alert_ctr_d = alert_ctr_q;
      if (trigger) begin
         state_d     = ST_ALERT;
         saved_d     = next_owner;
         alert_ctr_d = ALERT_RELOAD;
      end else if (in_alert) begin
         saved_d = next_owner;
         if (alert_ctr_q == '0) begin
            state_d = {1'b0, next_owner};
         end else begin
            alert_ctr_d = alert_ctr_q - AW'(1);
         end
      end else begin
         state_d = {1'b0, next_owner};
      end
   end

   always_comb begin
      wr_mask = i_wb_data[16 +: NLEDS];
      if (wr_mask == '0) wr_mask = '1;
      wr_val = i_wb_data[NLEDS-1:0];
      soft_d = wr_leds ? ((soft_q & ~wr_mask) | (wr_val & wr_mask)) : soft_q;
   end

   always_comb begin
      case (state_q)
         ST_SOFT:  leds_d = soft_q;
         ST_ALERT: leds_d = {NLEDS{alert_ctr_q[BLINKBIT]}};
         default:  leds_d = i_bounce;
      endcase
   end

   // Read data is captured from pre-write state so a write returns the old register value.
   always_comb begin
      rdata_d = rdata_q;
      if (i_wb_stb) begin
         case (i_wb_addr)
            2'd0:    rdata_d = {16'h0, 16'(soft_q)};
            2'd1:    rdata_d = {state_q, saved_q, 29'(alert_ctr_q)};
            default: rdata_d = '0;
         endcase
      end
   end

   assign ack_d = i_wb_cyc && i_wb_stb;

   // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q     <= ST_BOUNCE;
         saved_q     <= 1'b0;
         soft_q      <= '0;
         alert_ctr_q <= '0;
         leds_q      <= '0;
         ack_q       <= 1'b0;
         rdata_q     <= '0;
      end else begin
         state_q     <= state_d;
         saved_q     <= saved_d;
         soft_q      <= soft_d;
         alert_ctr_q <= alert_ctr_d;
         leds_q      <= leds_d;
         ack_q       <= ack_d;
         rdata_q     <= rdata_d;
      end
   end

   assign unused_bits = ^{i_wb_sel, i_wb_data};

   assign o_wb_stall = 1'b0;
   assign o_wb_ack   = ack_q;
   assign o_wb_data  = rdata_q;
   assign o_leds     = leds_q;

endmodule
